// File: rtl/square_wave_rom.sv
// square_wave_rom: read-only lookup table holding one period of a square wave
// for the DAC data path. The first half of the address range returns
// HIGH_VALUE and the second half returns LOW_VALUE, which gives a 50% duty
// cycle over one full address sweep. Reads are synchronous with one register
// stage, plus an optional second output register.
//
// Handshake: none. There is no valid/ready and no enable. A read is taken on
// every rising clk edge while rst is low, and rd_data is always meaningful
// once the pipeline has refilled after reset.
module square_wave_rom #(
  parameter int                        ADDR_WIDTH = 10,
  parameter int                        DATA_WIDTH = 8,
  parameter int                        OUTPUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0]     HIGH_VALUE = 8'hFF,
  parameter logic [DATA_WIDTH-1:0]     LOW_VALUE  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int HALF  = DEPTH / 2;

  // Contents of one table word, fixed at elaboration.
  function automatic logic [DATA_WIDTH-1:0] rom_word(input int a);
    return (a < HALF) ? HIGH_VALUE : LOW_VALUE;
  endfunction

  // Constant table; synthesis folds this into ROM contents.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = rom_word(i);
  end

  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;

  // Table lookup feeding the read register.
  always_comb begin
    rd_d = mem[addr];
  end

  // Read register: captures the addressed word every cycle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] out_q;

    // Second stage simply follows the read register.
    always_comb begin
      out_d = rd_q;
    end

    // Extra output register for timing; adds one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign rd_data = out_q;
  end else begin : g_no_out_reg
    assign rd_data = rd_q;
  end

endmodule

// File: tb/tb_square_wave_rom.sv
// Testbench for square_wave_rom. Three instances share clk/rst/addr:
//   dut_l1 : default contents, latency 1
//   dut_l2 : default contents, latency 2
//   dut_cv : HIGH_VALUE=C0 / LOW_VALUE=40, latency 1
// Addresses captured by the DUT are kept in a queue; expected words are
// computed from those addresses by a small table model.
module tb_square_wave_rom;

  localparam int AW = 10;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] rd_l1;
  logic [DW-1:0] rd_l2;
  logic [DW-1:0] rd_cv;

  always #5 clk = ~clk;

  square_wave_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) dut_l1 (
    .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_l1)
  );

  square_wave_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) dut_l2 (
    .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_l2)
  );

  square_wave_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0),
                    .HIGH_VALUE(8'hC0), .LOW_VALUE(8'h40)) dut_cv (
    .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_cv)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // Addresses captured at the most recent edges (newest at the back).
  logic [AW-1:0] addr_q[$];

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a,
                                               input logic [DW-1:0] hi,
                                               input logic [DW-1:0] lo);
    return (a < 10'd512) ? hi : lo;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all three outputs against the model.
  task automatic check_all(input string tag);
    logic [DW-1:0] e_l1, e_l2, e_cv;
    e_l1 = 8'h00;
    e_l2 = 8'h00;
    e_cv = 8'h00;
    if (addr_q.size() >= 1) begin
      e_l1 = model_word(addr_q[addr_q.size()-1], 8'hFF, 8'h00);
      e_cv = model_word(addr_q[addr_q.size()-1], 8'hC0, 8'h40);
    end
    if (addr_q.size() >= 2) begin
      e_l2 = model_word(addr_q[addr_q.size()-2], 8'hFF, 8'h00);
    end
    check({tag, "_l1"}, rd_l1, e_l1);
    check({tag, "_l2"}, rd_l2, e_l2);
    check({tag, "_cv"}, rd_cv, e_cv);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: apply addr, take one rising edge,
  // update the model, then check on the following falling edge.
  task automatic cycle(input logic [AW-1:0] a, input string tag);
    addr = a;
    @(posedge clk);
    if (rst) begin
      addr_q.delete();
    end else begin
      addr_q.push_back(a);
      if (addr_q.size() > 2) void'(addr_q.pop_front());
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Bound on total run time.
  initial begin
    #200us;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] bnd [5];
    bnd[0] = 10'd511;
    bnd[1] = 10'd512;
    bnd[2] = 10'd1023;
    bnd[3] = 10'd0;
    bnd[4] = 10'd1;

    // Reset held for 200 ns while addr wanders.
    rst = 1'b1;
    @(negedge clk);
    check_all("rst_start");
    for (int i = 0; i < 19; i++) begin
      cycle(AW'($urandom_range(0, 1023)), "rst_hold");
    end

    // Release and sweep the whole table.
    rst = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      cycle(AW'(a), "sweep");
    end
    // Wrap 1023 -> 0 continues the waveform.
    cycle(10'd0, "wrap0");
    cycle(10'd1, "wrap1");

    // Boundary vectors.
    for (int i = 0; i < 5; i++) begin
      cycle(bnd[i], "bound");
    end
    cycle(10'd2, "bound_tail");

    // Address change between edges must not reach rd_data.
    cycle(10'd3, "pre_comb");
    addr = 10'd700;
    #2;
    check("no_comb_l1", rd_l1, 8'hFF);
    check("no_comb_cv", rd_cv, 8'hC0);
    #1;
    addr = 10'd4;
    cycle(10'd4, "post_comb");
    cycle(10'd5, "post_comb");

    // Asynchronous reset between edges while output is FF.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_l1", rd_l1, 8'h00);
    check("async_rst_l2", rd_l2, 8'h00);
    check("async_rst_cv", rd_cv, 8'h00);
    addr_q.delete();
    @(negedge clk);
    cycle(10'd6, "rst_mid_hold");
    rst = 1'b0;
    // First edge after release: l1 valid, l2 still zero.
    cycle(10'd100, "resume1");
    check("resume1_l2_zero", rd_l2, 8'h00);
    cycle(10'd600, "resume2");
    check("resume2_l2_ff", rd_l2, 8'hFF);
    cycle(10'd601, "resume3");
    cycle(10'd10, "resume4");
    cycle(10'd11, "resume5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
